md_unit: RTL

- Iterative multiply/divide unit for the MIPS datapath.
- Consumes the two register-file read operands (rs in srcA, rt in srcB) and owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in a single cycle.
- Control stalls the pipeline on busy. MFHI/MFLO read hi/lo directly; the selected value goes back to the register-file write port.

---
 rtl/md_unit_pkg.sv | 34 +++
 rtl/md_unit_if.sv | 27 ++
 rtl/md_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the iterative multiply/divide unit.
//   - MD_WIDTH : default operand and HI/LO width
//   - mdOp_e   : operation codes presented on the op port
//   - mdState_e: control FSM states
//   - negWord / negDword: two's-complement negate, used for the
//     sign/magnitude conversion at load and the sign fix-up at commit.
package md_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdState_e;

    function automatic logic [MD_WIDTH-1:0] negWord(input logic [MD_WIDTH-1:0] v);
        return ~v + {{(MD_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*MD_WIDTH-1:0] negDword(input logic [2*MD_WIDTH-1:0] v);
        return ~v + {{(2*MD_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the datapath and md_unit.
//   start, op, srcA, srcB : request side (driven by the master)
//   busy, done, hi, lo    : status and HI/LO (driven by the unit)
interface md_unit_if
    import md_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning the MIPS HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : md_unit_if slave (start/op/srcA/srcB in; busy/done/hi/lo out)
// MULT/MULTU/DIV/DIVU take one load edge, WIDTH iteration edges and one
// commit edge; MTHI/MTLO write in the edge they are accepted. Requests are
// only looked at while idle.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic   clk,
    input  logic   reset,
    md_unit_if.slave bus
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdState_e           state, stateNext;
    logic [CNT_W-1:0]   cnt;
    mdOp_e              opReg;
    logic               negRes, negRem;
    logic [WIDTH-1:0]   bMag;
    logic [2*WIDTH-1:0] acc;

    logic               isMulDiv, loadEn, mthiEn, mtloEn, commitEn, isMulOp;
    logic               signA, signB;
    logic signed [WIDTH-1:0] srcAS, srcBS;
    logic [WIDTH-1:0]   aMag, bMagIn;
    logic [WIDTH:0]     mulSum, remShift, remTrial;
    logic               qBit;
    logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
    logic [WIDTH-1:0]   hiFix, loFix;

    assign srcAS    = bus.srcA;
    assign srcBS    = bus.srcB;
    assign isMulDiv = bus.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign isMulOp  = (opReg == OP_MULT) || (opReg == OP_MULTU);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start && isMulDiv) stateNext = RUN;
            RUN:     if (cnt == LAST) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        bus.busy = (state != IDLE);
        loadEn   = (state == IDLE) && bus.start && isMulDiv;
        mthiEn   = (state == IDLE) && bus.start && (bus.op == OP_MTHI);
        mtloEn   = (state == IDLE) && bus.start && (bus.op == OP_MTLO);
        commitEn = (state == FIX);
    end

    // Load: signed ops iterate on magnitudes; signs are re-applied at commit.
    // A zero divisor suppresses quotient negation so lo stays all ones, and
    // the dividend-signed remainder then reproduces srcA in hi.
    always_comb begin
        signA  = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && (srcAS < 0);
        signB  = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && (srcBS < 0);
        aMag   = signA ? negWord(bus.srcA) : bus.srcA;
        bMagIn = signB ? negWord(bus.srcB) : bus.srcB;
    end

    // Iteration: acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bMag} : '0);
        mulNext  = {mulSum, acc[WIDTH-1:1]};
        remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        remTrial = remShift - {1'b0, bMag};
        qBit     = (remShift >= {1'b0, bMag});
        divNext  = {(qBit ? remTrial[WIDTH-1:0] : remShift[WIDTH-1:0]),
                    acc[WIDTH-2:0], qBit};
    end

    // Commit: sign fix-up of the magnitude result
    always_comb begin
        prodFix = negRes ? negDword(acc) : acc;
        if (isMulOp) begin
            hiFix = prodFix[2*WIDTH-1:WIDTH];
            loFix = prodFix[WIDTH-1:0];
        end else begin
            hiFix = negRem ? negWord(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
            loFix = negRes ? negWord(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            acc    <= {{WIDTH{1'b0}}, aMag};
            bMag   <= bMagIn;
            opReg  <= mdOp_e'(bus.op);
            negRes <= ((bus.op == OP_MULT) && (signA ^ signB)) ||
                      ((bus.op == OP_DIV) && (signA ^ signB) && (bus.srcB != '0));
            negRem <= (bus.op == OP_DIV) && signA;
        end else if (state == RUN) begin
            acc <= isMulOp ? mulNext : divNext;
        end
    end

    // Architectural state: counter, done pulse, HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= commitEn;
            if (loadEn)              cnt <= '0;
            else if (state == RUN)   cnt <= cnt + 1'b1;
            if (commitEn) begin
                bus.hi <= hiFix;
                bus.lo <= loFix;
            end else begin
                if (mthiEn) bus.hi <= bus.srcA;
                if (mtloEn) bus.lo <= bus.srcA;
            end
        end
    end

endmodule
